// File: rtl/daq_pkg.sv
// daq_pkg: state encoding and register layouts shared by the readout controller.
package daq_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_READ      = 3'd3,
    S_RELEASE   = 3'd4
  } state_t;
  localparam int CTL_EN = 0;
  localparam int CTL_FORCE = 1;
  localparam int CTL_CH = 2;
  localparam int CTL_PRE_LSB = 3;
  localparam int CTL_THR_LSB = 16;
  localparam int STS_BUSY = 0;
  localparam int STS_STATE_LSB = 1;
  localparam int STS_FRAME_LSB = 16;
  function automatic logic [31:0] ctl_word(input logic [15:0] thr, input logic [12:0] pre,
                                           input logic ch, input logic frc, input logic en);
    logic [31:0] w;
    w = '0;
    w[CTL_EN] = en;
    w[CTL_FORCE] = frc;
    w[CTL_CH] = ch;
    w[CTL_PRE_LSB +: 13] = pre;
    w[CTL_THR_LSB +: 16] = thr;
    return w;
  endfunction
  function automatic logic [31:0] sts_word(input state_t s, input logic [15:0] frames);
    logic [31:0] w;
    w = '0;
    w[STS_BUSY] = s != S_IDLE;
    w[STS_STATE_LSB +: 3] = s;
    w[STS_FRAME_LSB +: 16] = frames;
    return w;
  endfunction
endpackage

// File: rtl/daq_skid_buf.sv
// daq_skid_buf: 2-entry output buffer carrying data+last; entry 0 drives the stream.
module daq_skid_buf #(
  parameter int W = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic [1:0]   occ
);
  logic [W:0] e0, e1;
  logic pop;
  assign pop = out_valid & out_ready;
  assign out_valid = occ != 2'd0;
  assign out_data = e0[W-1:0];
  assign out_last = e0[W];
  always_ff @(posedge aclk) begin
    if (!aresetn || flush) begin
      occ <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      occ <= occ - {1'b0, pop} + {1'b0, in_valid};
      if (pop) e0 <= occ == 2'd2 ? e1 : {in_last, in_data};
      else if (occ == 2'd0 && in_valid) e0 <= {in_last, in_data};
      if (in_valid && (occ - {1'b0, pop}) == 2'd1) e1 <= {in_last, in_data};
    end
  end
endmodule

// File: rtl/daq_readout_ctrl.sv
// daq_readout_ctrl: arms the DAQ core, waits for capture done and streams BRAM words out.
// Optional DAQ_AUTO_TRIGGER_EN adds a WAIT_DONE timeout that raises force_trigger.
module daq_readout_ctrl
  import daq_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 16,
  parameter int BRAM_DATA_WIDTH = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       cfg_start,
  input  logic                       cfg_auto_rearm,
  input  logic                       cfg_abort,
  input  logic [15:0]                cfg_threshold,
  input  logic [12:0]                cfg_pretrigger,
  input  logic                       cfg_channel,
  input  logic [BRAM_ADDR_WIDTH-1:0] cfg_rd_base,
  input  logic [BRAM_ADDR_WIDTH-1:0] cfg_rd_len,
  input  logic [31:0]                cfg_timeout,
  output logic [31:0]                daq_control,
  input  logic [31:0]                daq_status,
  output logic [31:0]                ctrl_status,
  output logic                       bram_portb_clk,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_portb_addr,
  output logic                       bram_portb_en,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_portb_rddata,
  output logic [BRAM_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready
);
  localparam int AW = BRAM_ADDR_WIDTH;
  state_t state, state_nxt;
  logic [15:0] thr_q, frames;
  logic [12:0] pre_q;
  logic ch_q, inflight, in_last, aborted, pop, last_beat, frc, done, unused_status;
  logic [AW-1:0] base_q, len_q, rd_addr;
  logic [AW:0] rem;
  logic [1:0] occ;
  logic [2:0] slot;
  assign done = daq_status[0];
  assign unused_status = ^daq_status[31:1];
  assign pop = m_axis_tvalid & m_axis_tready;
  assign last_beat = state == S_READ && pop && m_axis_tlast && !cfg_abort;
  // Words buffered after this edge plus the one landing from BRAM must leave room for a new read.
  assign slot = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign bram_portb_en = state == S_READ && rem != '0 && slot < 3'd2;
  assign bram_portb_addr = rd_addr;
  assign bram_portb_clk = aclk;
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (cfg_abort) state_nxt = S_RELEASE;
    else
      case (state)
        S_IDLE:      state_nxt = cfg_start ? S_ARM : S_IDLE;
        S_ARM:       state_nxt = S_WAIT_DONE;
        S_WAIT_DONE: state_nxt = done ? S_READ : S_WAIT_DONE;
        S_READ:      state_nxt = last_beat ? S_RELEASE : S_READ;
        S_RELEASE:   state_nxt = done ? S_RELEASE : (cfg_auto_rearm && !aborted) ? S_ARM : S_IDLE;
        default:     state_nxt = S_IDLE;
      endcase
  end
  always_comb begin
    daq_control = ctl_word(thr_q, pre_q, ch_q, frc, state inside {S_ARM, S_WAIT_DONE, S_READ});
    ctrl_status = sts_word(state, frames);
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      thr_q <= '0;
      pre_q <= '0;
      ch_q <= 1'b0;
      base_q <= '0;
      len_q <= '0;
      rd_addr <= '0;
      rem <= '0;
      inflight <= 1'b0;
      in_last <= 1'b0;
      frames <= '0;
      aborted <= 1'b0;
    end else begin
      if (state == S_IDLE && cfg_start) begin
        thr_q <= cfg_threshold;
        pre_q <= cfg_pretrigger;
        ch_q <= cfg_channel;
        base_q <= cfg_rd_base;
        len_q <= cfg_rd_len;
      end
      if (state == S_ARM) begin
        rd_addr <= base_q;
        rem <= len_q == '0 ? {1'b1, {AW{1'b0}}} : {1'b0, len_q};
      end else if (bram_portb_en) begin
        rd_addr <= rd_addr + 1'b1;
        rem <= rem - 1'b1;
      end
      inflight <= bram_portb_en;
      in_last <= bram_portb_en && rem == {{AW{1'b0}}, 1'b1};
      if (last_beat) frames <= frames + 1'b1;
      aborted <= cfg_abort | (aborted & (state != S_RELEASE | done));
    end
  end
`ifdef DAQ_AUTO_TRIGGER_EN
  logic [31:0] tmo_cnt;
  logic hit;
  assign hit = cfg_timeout != '0 && tmo_cnt == cfg_timeout;
  assign frc = state == S_WAIT_DONE && hit;
  always_ff @(posedge aclk) begin
    if (!aresetn || state != S_WAIT_DONE) tmo_cnt <= '0;
    else if (!hit) tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^cfg_timeout;
  assign frc = 1'b0;
`endif
  daq_skid_buf #(.W(BRAM_DATA_WIDTH)) u_skid (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .flush     (cfg_abort || state != S_READ),
    .in_valid  (inflight),
    .in_data   (bram_portb_rddata),
    .in_last   (in_last),
    .out_valid (m_axis_tvalid),
    .out_data  (m_axis_tdata),
    .out_last  (m_axis_tlast),
    .out_ready (m_axis_tready),
    .occ       (occ)
  );
endmodule

// File: tb/tb_daq_readout_ctrl.sv
// tb_daq_readout_ctrl: randomized frame runs checked against a queue-based model of the readout.
module tb_daq_readout_ctrl;
  logic aclk = 1'b0, aresetn = 1'b0, cfg_start = 1'b0, cfg_auto_rearm = 1'b0, cfg_abort = 1'b0;
  logic [15:0] cfg_threshold = '0, cfg_rd_base = '0, cfg_rd_len = '0;
  logic [12:0] cfg_pretrigger = '0;
  logic cfg_channel = 1'b0;
  logic [31:0] cfg_timeout = 32'd100, daq_status = '0;
  logic [31:0] daq_control, ctrl_status;
  logic bram_portb_clk, bram_portb_en, m_axis_tvalid, m_axis_tlast;
  logic m_axis_tready = 1'b1;
  logic [15:0] bram_portb_addr, bram_portb_rddata, m_axis_tdata;

  int n_tests = 0, n_fail = 0, cyc = 0, rmode = 0, ph = 0;
  int done_after = 20, en_cnt = 0, rel_cnt = 0, exp_frames = 0;
  int read_entry = 0, reads = 0, rearm_entries = 0;
  logic [2:0] st = '0, pst = '0;
  logic last_done = 1'b0, prev_stall = 1'b0, pl = 1'b0;
  bit fb = 1'b0;
  logic [15:0] pd = '0;
  logic [31:0] exp_ctl = '0;
  logic [15:0] got_data[$];
  bit got_last[$];
  int beat_cyc[$];
  logic [15:0] issued[$];

  always #5 aclk = ~aclk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  always @(posedge aclk) if (bram_portb_en) bram_portb_rddata <= mem(bram_portb_addr);

  daq_readout_ctrl dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_start(cfg_start), .cfg_auto_rearm(cfg_auto_rearm),
    .cfg_abort(cfg_abort), .cfg_threshold(cfg_threshold), .cfg_pretrigger(cfg_pretrigger),
    .cfg_channel(cfg_channel), .cfg_rd_base(cfg_rd_base), .cfg_rd_len(cfg_rd_len),
    .cfg_timeout(cfg_timeout), .daq_control(daq_control), .daq_status(daq_status),
    .ctrl_status(ctrl_status), .bram_portb_clk(bram_portb_clk), .bram_portb_addr(bram_portb_addr),
    .bram_portb_en(bram_portb_en), .bram_portb_rddata(bram_portb_rddata),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  // One clock: respond as the DAQ core, drive tready, then observe the cycle.
  task automatic tick();
    @(posedge aclk);
    #1;
    cyc++;
    if (daq_control[0]) begin
      rel_cnt = 0;
      if (en_cnt >= done_after) daq_status[0] = 1'b1;
      else en_cnt++;
    end else begin
      en_cnt = 0;
      if (daq_status[0]) begin
        if (rel_cnt >= 2) daq_status[0] = 1'b0;
        else rel_cnt++;
      end
    end
    m_axis_tready = rmode == 0 ? 1'b1 : rmode == 1 ? (ph % 4 == 0 || ph % 4 == 3) : 1'($urandom_range(0, 1));
    ph++;
    #1;
    st = ctrl_status[3:1];
    if (pst == 3'd4 && st == 3'd1) begin
      n_tests++;
      rearm_entries++;
      if (last_done !== 1'b0) begin n_fail++; $display("FAIL rearm_after_done: done=%b required 0", last_done); end
    end
    if (pst == 3'd1) begin
      n_tests++;
      if (st !== 3'd2 && st !== 3'd4) begin n_fail++; $display("FAIL arm_one_cycle: state=%0d required 2", st); end
    end
    if (st == 3'd1) begin
      n_tests++;
      if (daq_control !== exp_ctl) begin n_fail++; $display("FAIL arm_control: got %h required %h", daq_control, exp_ctl); end
    end
`ifndef DAQ_AUTO_TRIGGER_EN
    if (st == 3'd2) begin
      n_tests++;
      if (daq_control[1] !== 1'b0) begin n_fail++; $display("FAIL force_off: got %b required 0", daq_control[1]); end
    end
`endif
    if (st == 3'd3 && pst != 3'd3) begin
      read_entry = cyc;
      reads++;
      fb = 1'b1;
      n_tests++;
      if (ctrl_status[0] !== 1'b1) begin n_fail++; $display("FAIL busy_read: got %b required 1", ctrl_status[0]); end
    end
    if (prev_stall) begin
      n_tests++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tlast !== pl) begin
        n_fail++;
        $display("FAIL stall_stable: got v=%b d=%h l=%b required v=1 d=%h l=%b", m_axis_tvalid, m_axis_tdata, m_axis_tlast, pd, pl);
      end
    end
    if (m_axis_tvalid && fb) begin
      fb = 1'b0;
      if (rmode == 0) begin
        n_tests++;
        if (cyc - read_entry != 2) begin n_fail++; $display("FAIL first_latency: got %0d required 2", cyc - read_entry); end
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      got_data.push_back(m_axis_tdata);
      got_last.push_back(m_axis_tlast);
      beat_cyc.push_back(cyc);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    pd = m_axis_tdata;
    pl = m_axis_tlast;
    if (bram_portb_en) issued.push_back(bram_portb_addr);
    pst = st;
    last_done = daq_status[0];
  endtask

  task automatic do_frames(input logic [15:0] base, input logic [15:0] len, input int mode, input int nfr,
                           input int abort_at, input bit force_rearm, input bit poke);
    int L, limit, guard, exp_beats, bad, bad_i, aborted_tick;
    bit poked;
    logic [15:0] a;
    L = len == 0 ? 65536 : int'(len);
    got_data.delete(); got_last.delete(); beat_cyc.delete(); issued.delete();
    reads = 0; rearm_entries = 0; rmode = mode; ph = 0; poked = 0; aborted_tick = -1;
    cfg_rd_base = base; cfg_rd_len = len;
    cfg_threshold = 16'($urandom); cfg_pretrigger = 13'($urandom); cfg_channel = 1'($urandom);
    cfg_auto_rearm = force_rearm || nfr > 1;
    exp_ctl = {cfg_threshold, cfg_pretrigger, cfg_channel, 1'b0, 1'b1};
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    exp_beats = abort_at > 0 ? abort_at : nfr * L;
    limit = L * nfr * 4 + 500;
    guard = 0;
    while (!(got_data.size() >= exp_beats && pst == 3'd0) && guard < limit) begin
      tick();
      guard++;
      if (!force_rearm) cfg_auto_rearm = reads < nfr;
      if (poke && pst == 3'd2 && !poked) begin
        cfg_start = 1'b1; cfg_rd_base = ~base; cfg_rd_len = 16'd3; poked = 1;
      end else cfg_start = 1'b0;
      if (abort_at > 0 && aborted_tick < 0 && got_data.size() == abort_at) begin
        cfg_abort = 1'b1;
        aborted_tick = guard;
      end else if (aborted_tick >= 0 && guard == aborted_tick + 1) begin
        n_tests++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL abort_tvalid: got %b required 0", m_axis_tvalid); end
        cfg_abort = 1'b0;
      end
    end
    n_tests++;
    if (guard >= limit) begin n_fail++; $display("FAIL frame_timeout: got %0d cycles required < %0d", guard, limit); end
    n_tests++;
    if (got_data.size() != exp_beats) begin n_fail++; $display("FAIL beat_count: got %0d required %0d", got_data.size(), exp_beats); end
    bad = 0; bad_i = -1;
    foreach (got_data[i]) begin
      a = 16'(base + (i % L));
      if (got_data[i] !== mem(a) || got_last[i] !== (abort_at == 0 && i % L == L - 1)) begin
        bad++;
        if (bad_i < 0) bad_i = i;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL beat_payload: got %0d bad beats (first %0d: d=%h l=%b) required data %h", bad, bad_i,
               got_data[bad_i], got_last[bad_i], mem(16'(base + (bad_i % L))));
    end
    if (abort_at == 0) begin
      bad = 0;
      foreach (issued[i]) if (issued[i] !== 16'(base + (i % L))) bad++;
      n_tests++;
      if (issued.size() != nfr * L || bad != 0) begin
        n_fail++;
        $display("FAIL read_addrs: got %0d reads %0d wrong required %0d reads from %h", issued.size(), bad, nfr * L, base);
      end
      exp_frames += nfr;
    end
    n_tests++;
    if (ctrl_status[31:16] !== 16'(exp_frames)) begin
      n_fail++; $display("FAIL frame_count: got %0d required %0d", ctrl_status[31:16], exp_frames);
    end
    n_tests++;
    if (ctrl_status[15:0] !== 16'h0) begin n_fail++; $display("FAIL end_idle: got %h required 0000", ctrl_status[15:0]); end
    if (nfr > 1) begin
      n_tests++;
      if (rearm_entries != nfr - 1) begin n_fail++; $display("FAIL rearm_count: got %0d required %0d", rearm_entries, nfr - 1); end
    end
    if (mode == 0 && abort_at == 0 && nfr == 1 && beat_cyc.size() == L) begin
      n_tests++;
      if (beat_cyc[L-1] - beat_cyc[0] != L - 1) begin
        n_fail++; $display("FAIL throughput: got %0d cycles required %0d", beat_cyc[L-1] - beat_cyc[0], L - 1);
      end
    end
    cfg_auto_rearm = 1'b0;
    cfg_abort = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    n_tests += 4;
    if (daq_control !== 32'h0) begin n_fail++; $display("FAIL rst_control: got %h required 0", daq_control); end
    if (ctrl_status !== 32'h0) begin n_fail++; $display("FAIL rst_status: got %h required 0", ctrl_status); end
    if (bram_portb_en !== 1'b0 || bram_portb_addr !== 16'h0) begin
      n_fail++; $display("FAIL rst_bram: got en=%b addr=%h required 0", bram_portb_en, bram_portb_addr);
    end
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 16'h0) begin
      n_fail++; $display("FAIL rst_axis: got v=%b l=%b d=%h required 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();     do_frames(16'h0010, 16'd4, 0, 1, 0, 0, 1); endtask
  task automatic test_wrap();      do_frames(16'hFFFE, 16'd4, 0, 1, 0, 0, 0); endtask
  task automatic test_backpressure(); do_frames(16'($urandom), 16'd8, 1, 1, 0, 0, 0); endtask
  task automatic test_auto_rearm(); do_frames(16'h0200, 16'd5, 0, 2, 0, 0, 0); endtask
  task automatic test_abort();     do_frames(16'h0040, 16'd8, 0, 1, 3, 1, 0); endtask
  task automatic test_len_zero();  do_frames(16'h1234, 16'd0, 0, 1, 0, 0, 0); endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) do_frames(16'($urandom), 16'($urandom_range(1, 12)), 2, 1, 0, 0, 0);
  endtask

  task automatic test_reset_mid_read();
    int g;
    bit seen;
    rmode = 0;
    got_data.delete(); got_last.delete(); beat_cyc.delete(); issued.delete();
    cfg_rd_base = 16'h0100; cfg_rd_len = 16'd20; cfg_auto_rearm = 1'b0;
    exp_ctl = {cfg_threshold, cfg_pretrigger, cfg_channel, 1'b0, 1'b1};
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    g = 0;
    while (got_data.size() < 2 && g < 300) begin tick(); g++; end
    n_tests++;
    if (got_data.size() < 2) begin n_fail++; $display("FAIL midread_reach: got %0d beats required 2", got_data.size()); end
    aresetn = 1'b0;
    tick(); tick();
    n_tests += 2;
    if (m_axis_tvalid !== 1'b0 || ctrl_status !== 32'h0) begin
      n_fail++; $display("FAIL midread_rst: got v=%b sts=%h required 0", m_axis_tvalid, ctrl_status);
    end
    if (daq_control !== 32'h0) begin n_fail++; $display("FAIL midread_ctl: got %h required 0", daq_control); end
    aresetn = 1'b1;
    seen = 0;
    repeat (8) begin tick(); if (m_axis_tvalid !== 1'b0) seen = 1; end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL midread_partial: got tvalid after reset required none"); end
    exp_frames = 0;
  endtask

`ifdef DAQ_AUTO_TRIGGER_EN
  task automatic test_auto_trigger();
    int wd, hitc, g;
    done_after = 1000000;
    cfg_timeout = 32'd100;
    rmode = 0;
    cfg_rd_base = 16'h0; cfg_rd_len = 16'd4;
    exp_ctl = {cfg_threshold, cfg_pretrigger, cfg_channel, 1'b0, 1'b1};
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wd = -1; hitc = -1; g = 0;
    while (hitc < 0 && g < 400) begin
      tick(); g++;
      if (pst == 3'd2 && wd < 0) wd = cyc;
      if (wd >= 0 && daq_control[1]) hitc = cyc;
    end
    n_tests++;
    if (hitc < 0 || hitc - wd != 100) begin n_fail++; $display("FAIL force_time: got %0d required 100", hitc - wd); end
    tick();
    n_tests++;
    if (daq_control[1] !== 1'b1) begin n_fail++; $display("FAIL force_hold: got %b required 1", daq_control[1]); end
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    g = 0;
    while (pst != 3'd0 && g < 50) begin tick(); g++; end
    n_tests++;
    if (pst != 3'd0 || daq_control[1] !== 1'b0) begin
      n_fail++; $display("FAIL force_exit: got state=%0d force=%b required 0", pst, daq_control[1]);
    end
    done_after = 20;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_auto_rearm();
    test_abort();
    test_random();
    test_reset_mid_read();
    test_len_zero();
`ifdef DAQ_AUTO_TRIGGER_EN
    test_auto_trigger();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/daq_readout_ctrl.md
DAQ_READOUT_CTRL -- requirements
Module: daq_readout_ctrl

Interface
REQ-001 SHALL have parameter BRAM_ADDR_WIDTH, default 16, BRAM address width.
REQ-002 SHALL have parameter BRAM_DATA_WIDTH, default 16, sample width, also used as m_axis_tdata width.
REQ-003 SHALL have port aclk, input, 1, clock; all logic on rising edge.
REQ-004 SHALL have port aresetn, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port cfg_start, input, 1, single-cycle pulse that starts one acquisition.
REQ-006 SHALL have port cfg_auto_rearm, input, 1, re-arm automatically after each readout.
REQ-007 SHALL have port cfg_abort, input, 1, level that forces return to IDLE.
REQ-008 SHALL have port cfg_threshold, input, 16, signed trigger level.
REQ-009 SHALL have port cfg_pretrigger, input, 13, pretrigger samples.
REQ-010 SHALL have port cfg_channel, input, 1; 0 selects CH1, 1 selects CH2.
REQ-011 SHALL have port cfg_rd_base, input, BRAM_ADDR_WIDTH, first readout address.
REQ-012 SHALL have port cfg_rd_len, input, BRAM_ADDR_WIDTH, words per frame; 0 means 2^BRAM_ADDR_WIDTH.
REQ-013 SHALL have port cfg_timeout, input, 32, auto-trigger timeout in cycles.
REQ-014 SHALL have port daq_control, output, 32: [31:16] threshold, [15:3] pretrigger, [2] channel, [1] force_trigger, [0] enable.
REQ-015 SHALL have port daq_status, input, 32; bit [0] is capture done.
REQ-016 SHALL have port ctrl_status, output, 32: [0] busy, [3:1] state code, [15:4] 0, [31:16] frame counter.
REQ-017 SHALL have ports bram_portb_clk (=aclk), bram_portb_addr, bram_portb_en, all outputs, and bram_portb_rddata, input, BRAM_DATA_WIDTH; read latency is exactly 1 cycle.
REQ-018 SHALL have AXI-Stream master ports m_axis_tdata, m_axis_tvalid, m_axis_tlast (outputs) and m_axis_tready (input).

Function
REQ-019 SHALL implement FSM IDLE(0), ARM(1), WAIT_DONE(2), READ(3), RELEASE(4).
REQ-020 IDLE->ARM SHALL occur on cfg_start=1; in IDLE, cfg_threshold, cfg_pretrigger, cfg_channel, cfg_rd_base and cfg_rd_len SHALL be latched on that edge.
REQ-021 ARM SHALL drive daq_control[0]=1 with latched fields, last exactly 1 cycle, then go to WAIT_DONE.
REQ-022 WAIT_DONE SHALL hold enable=1 and go to READ on the first cycle daq_status[0]=1.
REQ-023 READ SHALL issue reads at rd_base, rd_base+1, ... modulo 2^BRAM_ADDR_WIDTH (wrap-around), for exactly rd_len words.
REQ-024 Address SHALL advance only when the issued word is guaranteed a slot: 2-entry output skid buffer, bram_portb_en=1 only when (occupancy + in-flight) < 2.
REQ-025 m_axis_tvalid SHALL stay asserted and tdata/tlast stable until tready=1 (AXI-Stream rules); tlast=1 only on the rd_len-th word.
REQ-026 With tready held at 1, throughput SHALL be 1 word/cycle; the first tvalid SHALL appear 2 cycles after READ entry.
REQ-027 READ->RELEASE SHALL occur on the cycle the tlast beat handshakes; frame counter SHALL increment (16-bit, wraps) on that cycle.
REQ-028 RELEASE SHALL drive enable=0 and wait for daq_status[0]=0, then go to ARM if cfg_auto_rearm=1, else IDLE.
REQ-029 cfg_abort=1 in any state SHALL go to RELEASE next cycle, flush the skid buffer, drop tvalid without a tlast, and skip the frame-counter increment; after RELEASE it SHALL go to IDLE regardless of cfg_auto_rearm.
REQ-030 cfg_start SHALL be ignored outside IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE.

Reset
REQ-032 On aresetn=0: state IDLE, daq_control=0, ctrl_status=0, bram_portb_en=0, bram_portb_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, skid buffer empty, frame counter 0.
REQ-033 Reset mid-READ SHALL discard all data with no partial beat after release.

Configuration
REQ-034 With macro DAQ_AUTO_TRIGGER_EN defined: a 32-bit counter SHALL clear on WAIT_DONE entry and count each cycle in WAIT_DONE; at count==cfg_timeout (nonzero) daq_control[1] SHALL assert and hold until WAIT_DONE exits; cfg_timeout=0 disables it.
REQ-035 Without DAQ_AUTO_TRIGGER_EN: daq_control[1] SHALL be constant 0, cfg_timeout SHALL be unused, and no counter logic SHALL be present.

Structure
REQ-036 Shared package daq_pkg SHALL hold the state encoding, daq_control bit-field positions and the ctrl_status layout.
REQ-037 The skid buffer SHALL be a sub-module daq_skid_buf (2 entries, data+last).

Verification
REQ-038 base=0x0010, len=4, tready=1, done after 20 cycles -> beats at addresses 0x10..0x13, tlast on the 4th, frame counter=1, back in IDLE.
REQ-039 base=0xFFFE, len=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-040 len=8 with tready toggled 1,0,0,1 repeating -> 8 beats in order, none lost or duplicated, payload stable while stalled.
REQ-041 auto_rearm=1, two frames -> ARM re-entered only after daq_status[0] falls, frame counter=2.
REQ-042 cfg_abort asserted on the 3rd READ beat -> tvalid low next cycle, no tlast, frame counter unchanged, state IDLE.
REQ-043 DAQ_AUTO_TRIGGER_EN defined, cfg_timeout=100, no done -> daq_control[1]=1 exactly 100 cycles after WAIT_DONE entry.
